// File: rtl/pitch_to_cv_pkg.sv
// pitch_to_cv_pkg: shared types and constants for the pitch tracker.
//   cmp_state_e  - hysteresis comparator state (LOW / HIGH)
//   cv_state_e   - period-to-V/Oct converter state (IDLE / NORM / LOOKUP / SUM)
//   log2_lut_entry() - one entry of the mantissa table,
//                      round(4000 * log2(1 + i/256)), evaluated at elaboration
package pitch_to_cv_pkg;

  typedef enum logic {CMP_LOW, CMP_HIGH} cmp_state_e;
  typedef enum logic [1:0] {CV_IDLE, CV_NORM, CV_LOOKUP, CV_SUM} cv_state_e;

  localparam int COUNTS_PER_VOLT = 4000;
  localparam int GATE_HIGH       = 20000;
  localparam int SQUARE_AMP      = 20000;

  // Fractional log2 by repeated squaring in 1.30 fixed point: each squaring
  // doubles the log, so an overflow past 2.0 yields the next fraction bit.
  // This reproduces log2_lut.hex without needing the file at build time.
  function automatic logic [11:0] log2_lut_entry(input int unsigned i);
    logic [63:0] x;
    logic [31:0] frac;
    logic [63:0] acc;
    x    = 64'(256 + i) << 22;
    frac = '0;
    for (int k = 0; k < 20; k++) begin
      x    = (x * x) >> 30;
      frac = frac << 1;
      if (x[31]) begin
        frac[0] = 1'b1;
        x       = x >> 1;
      end
    end
    acc = 64'(frac) * 64'(COUNTS_PER_VOLT) + 64'(1 << 19);
    return acc[31:20];
  endfunction

endpackage

// File: rtl/period_log2.sv
// period_log2: converts a period in samples to V/Oct counts,
//   r = CV_OFFSET - 4000*e - LUT[m], with P normalised to 1.m * 2^e.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (abandons a conversion)
//   start_i    - start strobe; ignored unless idle (crossing dropped)
//   period_i   - period P in samples, must be nonzero
//   done_o     - one-cycle strobe, r_o valid with it
//   r_o        - result saturated to 16-bit signed
module period_log2
  import pitch_to_cv_pkg::*;
#(
  parameter int CV_OFFSET = 46078
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [15:0]        period_i,
  output logic               done_o,
  output logic signed [15:0] r_o
);

  localparam logic signed [17:0] OFS = 18'(CV_OFFSET);

  cv_state_e          state_q;
  logic [15:0]        norm_q;
  logic [3:0]         shift_q;
  logic [11:0]        lut_q;
  logic               done_q;
  logic signed [15:0] r_q;

  logic [11:0] lut [256];
  for (genvar gi = 0; gi < 256; gi++) begin : g_lut
    localparam logic [11:0] ENTRY = log2_lut_entry(gi);
    assign lut[gi] = ENTRY;
  end

  logic [3:0]         exp_w;
  logic [17:0]        ev_w;
  logic signed [17:0] r_w;
  logic signed [15:0] r_sat;

  assign exp_w = 4'd15 - shift_q;
  assign ev_w  = 18'(COUNTS_PER_VOLT) * {14'd0, exp_w};
  assign r_w   = OFS - $signed(ev_w) - $signed({6'd0, lut_q});

  always_comb begin
    r_sat = r_w[15:0];
    if (r_w > 18'sd32767)       r_sat = 16'sh7fff;
    else if (r_w < -18'sd32768) r_sat = 16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CV_IDLE;
      norm_q  <= '0;
      shift_q <= '0;
      lut_q   <= '0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CV_IDLE: begin
          // A zero period would never normalise; never sent, but keep it safe.
          if (start_i && period_i != '0) begin
            norm_q  <= period_i;
            shift_q <= '0;
            state_q <= CV_NORM;
          end
        end
        CV_NORM: begin
          if (norm_q[15]) begin
            state_q <= CV_LOOKUP;
          end else begin
            norm_q  <= norm_q << 1;
            shift_q <= shift_q + 4'd1;
          end
        end
        CV_LOOKUP: begin
          lut_q   <= lut[norm_q[14:7]];
          state_q <= CV_SUM;
        end
        CV_SUM: begin
          r_q     <= r_sat;
          done_q  <= 1'b1;
          state_q <= CV_IDLE;
        end
        default: state_q <= CV_IDLE;
      endcase
    end
  end

  assign done_o = done_q;
  assign r_o    = r_q;

endmodule

// File: rtl/pitch_to_cv.sv
// pitch_to_cv: pitch tracker, audio period in -> 1V/Oct CV out (C3 = +3V).
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   sample_clk        - sample strobe; rising edge of its registered copy = tick
//   sample_in0        - audio to track; sample_in1..3, jack unused
//   sample_out0       - V/Oct CV (holds across timeouts)
//   sample_out1       - lock gate, GATE_HIGH when locked
//   sample_out2       - squared input, +/-SQUARE_AMP from comparator state
//   sample_out3       - constant 0
// Build option: define PITCH_TO_CV_SLEW_EN for a one-pole glide on
// sample_out0, y += (r - y) >>> 3 per conversion.
module pitch_to_cv
  import pitch_to_cv_pkg::*;
#(
  parameter int W          = 16,
  parameter int HYST       = 400,
  parameter int PERIOD_MIN = 4,
  parameter int PERIOD_MAX = 4800,
  parameter int CV_OFFSET  = 46078
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  input  logic [7:0]          jack
);

  localparam logic signed [W-1:0] HYST_POS = W'(HYST);
  localparam logic signed [W-1:0] HYST_NEG = W'(-HYST);
  localparam logic [15:0]         PMIN     = 16'(PERIOD_MIN);
  localparam logic [15:0]         PMAX     = 16'(PERIOD_MAX);
  localparam logic signed [W-1:0] GATE_ON  = W'(GATE_HIGH);
  localparam logic signed [W-1:0] SQ_HI    = W'(SQUARE_AMP);
  localparam logic signed [W-1:0] SQ_LO    = W'(-SQUARE_AMP);

  logic               sclk_q, sclk_prev_q, tick;
  cmp_state_e         cmp_q, cmp_d;
  logic [15:0]        cnt_q, cnt_d, cnt_inc, p_q, p_d, p_meas;
  logic               armed_q, armed_d;
  logic [1:0]         vcnt_q, vcnt_d;
  logic               start_q, start_d, rise;
  logic signed [W-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
  logic               conv_done;
  logic signed [15:0] conv_r;
`ifdef PITCH_TO_CV_SLEW_EN
  logic signed [18:0] y_q, y_d;
  logic               first_q, first_d;
`endif

  logic unused_in;
  assign unused_in = ^{sample_in1, sample_in2, sample_in3, jack};

  assign tick = sclk_q & ~sclk_prev_q;

  always_comb begin
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    armed_d = armed_q;
    vcnt_d  = vcnt_q;
    start_d = 1'b0;
    out0_d  = out0_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    rise    = 1'b0;
`ifdef PITCH_TO_CV_SLEW_EN
    y_d     = y_q;
    first_d = first_q;
`endif
    cnt_inc = (cnt_q >= PMAX) ? PMAX : cnt_q + 16'd1;
    // The crossing tick itself counts toward the period.
    p_meas  = cnt_q + 16'd1;

    if (tick) begin
      if (cmp_q == CMP_LOW && sample_in0 > HYST_POS) begin
        cmp_d = CMP_HIGH;
        rise  = 1'b1;
      end else if (cmp_q == CMP_HIGH && sample_in0 < HYST_NEG) begin
        cmp_d = CMP_LOW;
      end
      out2_d = (cmp_d == CMP_HIGH) ? SQ_HI : SQ_LO;

      if (rise) begin
        cnt_d = '0;
        // Glitch-short periods neither arm nor convert.
        if (p_meas >= PMIN) begin
          if (!armed_q) begin
            armed_d = 1'b1;
`ifdef PITCH_TO_CV_SLEW_EN
            first_d = 1'b1;
`endif
          end else begin
            start_d = 1'b1;
            p_d     = p_meas;
            vcnt_d  = (vcnt_q == 2'd2) ? 2'd2 : vcnt_q + 2'd1;
          end
        end
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == PMAX) begin
          armed_d = 1'b0;
          vcnt_d  = '0;
        end
      end
      out1_d = (vcnt_d == 2'd2) ? GATE_ON : '0;
    end

    if (conv_done) begin
`ifdef PITCH_TO_CV_SLEW_EN
      if (first_q) y_d = 19'(conv_r);
      else         y_d = y_q + ((19'(conv_r) - y_q) >>> 3);
      first_d = 1'b0;
      out0_d  = W'(y_d);
`else
      out0_d = W'(conv_r);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      cmp_q       <= CMP_LOW;
      cnt_q       <= '0;
      p_q         <= '0;
      armed_q     <= 1'b0;
      vcnt_q      <= '0;
      start_q     <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
`ifdef PITCH_TO_CV_SLEW_EN
      y_q         <= '0;
      first_q     <= 1'b1;
`endif
    end else begin
      sclk_q      <= sample_clk;
      sclk_prev_q <= sclk_q;
      cmp_q       <= cmp_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      armed_q     <= armed_d;
      vcnt_q      <= vcnt_d;
      start_q     <= start_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
`ifdef PITCH_TO_CV_SLEW_EN
      y_q         <= y_d;
      first_q     <= first_d;
`endif
    end
  end

  period_log2 #(.CV_OFFSET(CV_OFFSET)) u_period_log2 (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_q),
    .period_i (p_q),
    .done_o   (conv_done),
    .r_o      (conv_r)
  );

  assign sample_out0 = out0_q;
  assign sample_out1 = out1_q;
  assign sample_out2 = out2_q;
  assign sample_out3 = '0;

endmodule

// File: tb/tb_pitch_to_cv.sv
module tb_pitch_to_cv;
  localparam int HYST = 400;
  localparam int PMIN = 4;
  localparam int PMAX = 4800;
  localparam int TOL  = 24;

  logic clk = 1'b0;
  logic rst, sample_clk;
  logic signed [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic [7:0] jack;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_high, m_armed;
  int m_cnt, m_valid, m_out0, m_out1, m_out2;

  pitch_to_cv dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .sample_in2(sample_in2), .sample_in3(sample_in3),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3),
    .jack(jack)
  );

  always #5 clk = ~clk;

  // Ideal V/Oct for a period: CV_OFFSET - 4000*log2(P), saturated.
  function automatic int exp_cv(input int p);
    real r;
    r = 46078.0 - 4000.0 * $ln(real'(p)) / $ln(2.0);
    if (r > 32767.0)  r = 32767.0;
    if (r < -32768.0) r = -32768.0;
    return int'(r);
  endfunction

  task automatic model_reset();
    m_high = 0; m_armed = 0; m_cnt = 0; m_valid = 0;
    m_out0 = 0; m_out1 = 0; m_out2 = 0;
  endtask

  function automatic bit model_tick(input int v);
    bit r;
    int p;
    r = 0;
    if (!m_high && v > HYST) begin m_high = 1; r = 1; end
    else if (m_high && v < -HYST) m_high = 0;
    m_out2 = m_high ? 20000 : -20000;
    if (r) begin
      p = m_cnt + 1;
      m_cnt = 0;
      if (p >= PMIN) begin
        if (!m_armed) m_armed = 1;
        else begin
          m_valid = (m_valid < 2) ? m_valid + 1 : 2;
          m_out0 = exp_cv(p);
        end
      end
    end else begin
      if (m_cnt < PMAX) m_cnt++;
      if (m_cnt == PMAX) begin m_valid = 0; m_armed = 0; end
    end
    m_out1 = (m_valid == 2) ? 20000 : 0;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out0"}, int'(sample_out0), 0, 0);
    chk({tag, "_out1"}, int'(sample_out1), 0, 0);
    chk({tag, "_out2"}, int'(sample_out2), 0, 0);
    chk({tag, "_out3"}, int'(sample_out3), 0, 0);
  endtask

  // Called just after a negedge; one sample is two clk cycles, with extra
  // settle time after a rising crossing so the conversion can finish.
  task automatic do_sample(input int v);
    bit r;
    sample_in0 = 16'(v);
    sample_clk = 1'b1;
    @(negedge clk) sample_clk = 1'b0;
    @(negedge clk);
    r = model_tick(v);
    if (r) repeat (24) @(negedge clk);
    chk("cv", int'(sample_out0), m_out0, TOL);
    chk("gate", int'(sample_out1), m_out1, 0);
    chk("square", int'(sample_out2), m_out2, 0);
  endtask

  task automatic run_square(input int period, input int ncyc);
    int lo;
    lo = period / 2;
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < lo; k++) do_sample(-8000);
      for (int k = 0; k < period - lo; k++) do_sample(8000);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct { int period; int ncyc; int exp0; int exp1; } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{367, 3, 12000, 20000};
    tbl[1] = '{734, 3,  8000, 20000};
    tbl[2] = '{ 32, 4, 26078, 20000};
    tbl[3] = '{  8, 4, 32767, 20000};
    tbl[4] = '{  4, 6, 32767, 20000};  // shortest accepted period
    tbl[5] = '{  3, 6,     0,     0};  // below minimum: rejected
    tbl[6] = '{367, 2, 12000,     0};  // one conversion, not yet locked
    tbl[7] = '{ 16, 4, 30078, 20000};

    rst = 1'b1; sample_clk = 1'b0;
    sample_in0 = '0; sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
    jack = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      apply_reset();
      run_square(tbl[i].period, tbl[i].ncyc);
      chk($sformatf("tbl%0d_p%0d_cv", i, tbl[i].period), int'(sample_out0), tbl[i].exp0, TOL);
      chk($sformatf("tbl%0d_p%0d_gate", i, tbl[i].period), int'(sample_out1), tbl[i].exp1, 0);
    end

    // Lock, then silence until the period counter times out.
    apply_reset();
    run_square(367, 3);
    chk("timeout_locked", int'(sample_out1), 20000, 0);
    for (int k = 0; k < 4800; k++) do_sample(0);
    chk("timeout_gate", int'(sample_out1), 0, 0);
    chk("timeout_hold_cv", int'(sample_out0), 12000, TOL);

    // Triangle inside the hysteresis band never crosses.
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      int ph;
      ph = k % 28;
      do_sample(ph < 14 ? -399 + ph * 57 : 399 - (ph - 14) * 57);
    end
    chk("tri_square", int'(sample_out2), -20000, 0);
    chk("tri_gate", int'(sample_out1), 0, 0);
    chk("tri_cv", int'(sample_out0), 0, 0);

    // Reset while the converter is normalising.
    apply_reset();
    run_square(367, 2);
    for (int k = 0; k < 183; k++) do_sample(-8000);
    sample_in0 = 16'sd8000;
    sample_clk = 1'b1;
    @(negedge clk) sample_clk = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_norm");
    rst = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    chk("rst_norm_abandon", int'(sample_out0), 0, 0);
    run_square(367, 2);
    chk("rst_relock_2x_gate", int'(sample_out1), 0, 0);
    chk("rst_relock_2x_cv", int'(sample_out0), 12000, TOL);
    run_square(367, 1);
    chk("rst_relock_3x_gate", int'(sample_out1), 20000, 0);

    // Random periods, duty and amplitudes, with occasional in-band samples.
    for (int t = 0; t < 5; t++) begin
      int p, lo, v;
      apply_reset();
      p  = int'($urandom_range(200, 5));
      lo = int'($urandom_range(p - 1, 1));
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < p; k++) begin
          v = int'($urandom_range(20000, 401));
          if (k < lo) v = -v;
          if ($urandom_range(7, 0) == 0) v = int'($urandom_range(798, 0)) - 399;
          do_sample(v);
        end
      end
      chk($sformatf("rand%0d_p%0d_cv", t, p), int'(sample_out0), m_out0, TOL);
      chk($sformatf("rand%0d_p%0d_gate", t, p), int'(sample_out1), m_out1, 0);
    end

    chk("out3_const", int'(sample_out3), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
